matrix_key_emulator: RTL and testbench

- Behavioural and synthesizable model of a 4x4 membrane keypad: the switch-matrix end of the row-scan/column-sense keypad interface.
- Watches the row lines driven by the keypad scanner and pulls the matching column line low while a requested key is "pressed". Press and release contact bounce is included.
- Used as the keypad stand-in in lock-level benches and in the board self-test build. It is fed by a script sequencer through a ready/request handshake.

---
 rtl/matrix_key_emulator.sv | 162 ++++++++++++++++
 tb/tb_matrix_key_emulator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_key_emulator.sv
// 4x4 membrane keypad model: latches a requested key, then closes its switch with optional contact bounce.
// Build option: define KEYEMU_BOUNCE_EN to add the BOUNCE_IN/BOUNCE_OUT phases around HOLD.
module matrix_key_emulator #(
  parameter int HOLD_CYCLES   = 50,
  parameter int BOUNCE_CYCLES = 5,
  parameter int GAP_CYCLES    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press_req,
  input  logic [3:0] press_code,
  output logic       press_ready,
  input  logic [3:0] lin_matrix,
  output logic [3:0] col_matrix,
  output logic       busy,
  output logic       done
);

  localparam int HOLD_N = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int GAP_N  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int HG_MAX = (HOLD_N > GAP_N) ? HOLD_N : GAP_N;
  localparam int MAX_N  = (BOUNCE_CYCLES > HG_MAX) ? BOUNCE_CYCLES : HG_MAX;
  localparam int CW     = $clog2(MAX_N) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_N - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_N - 1);

`ifdef KEYEMU_BOUNCE_EN
  localparam logic [CW-1:0] BOUNCE_LAST = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`endif

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt, nxt_cnt, cnt_inc;
  logic [1:0]      key_row, key_col, nxt_row, nxt_col;
  logic            contact;

  function automatic logic [3:0] decode(input logic [3:0] code);
    case (code)
      4'h1: decode = 4'b00_00;
      4'h2: decode = 4'b00_01;
      4'h3: decode = 4'b00_10;
      4'hA: decode = 4'b00_11;
      4'h4: decode = 4'b01_00;
      4'h5: decode = 4'b01_01;
      4'h6: decode = 4'b01_10;
      4'hB: decode = 4'b01_11;
      4'h7: decode = 4'b10_00;
      4'h8: decode = 4'b10_01;
      4'h9: decode = 4'b10_10;
      4'hC: decode = 4'b10_11;
      4'hE: decode = 4'b11_00;
      4'h0: decode = 4'b11_01;
      4'hF: decode = 4'b11_10;
      default: decode = 4'b11_11;
    endcase
  endfunction

  // Contact level for a given phase position; bounce phases toggle on counter parity.
  function automatic logic contact_of(input state_t st, input logic [CW-1:0] k);
    case (st)
`ifdef KEYEMU_BOUNCE_EN
      BOUNCE_IN:  contact_of = k[0];
      BOUNCE_OUT: contact_of = ~k[0];
`endif
      HOLD:       contact_of = 1'b1;
      default:    contact_of = 1'b0;
    endcase
  endfunction

  // Saturating increment: the counter never wraps even if a bound is missed.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_row   = key_row;
    nxt_col   = key_col;
    case (state)
      IDLE: begin
        if (press_req && press_ready) begin
          {nxt_row, nxt_col} = decode(press_code);
          nxt_cnt = '0;
`ifdef KEYEMU_BOUNCE_EN
          nxt_state = (BOUNCE_CYCLES == 0) ? HOLD : BOUNCE_IN;
`else
          nxt_state = HOLD;
`endif
        end
      end
`ifdef KEYEMU_BOUNCE_EN
      BOUNCE_IN: begin
        nxt_cnt = cnt_inc;
        if (cnt == BOUNCE_LAST) begin
          nxt_state = HOLD;
          nxt_cnt   = '0;
        end
      end
      BOUNCE_OUT: begin
        nxt_cnt = cnt_inc;
        if (cnt == BOUNCE_LAST) begin
          nxt_state = GAP;
          nxt_cnt   = '0;
        end
      end
`endif
      HOLD: begin
        nxt_cnt = cnt_inc;
        if (cnt == HOLD_LAST) begin
`ifdef KEYEMU_BOUNCE_EN
          nxt_state = (BOUNCE_CYCLES == 0) ? GAP : BOUNCE_OUT;
`else
          nxt_state = GAP;
`endif
          nxt_cnt = '0;
        end
      end
      GAP: begin
        nxt_cnt = cnt_inc;
        if (cnt == GAP_LAST) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      key_row     <= 2'd0;
      key_col     <= 2'd0;
      contact     <= 1'b0;
      press_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      key_row     <= nxt_row;
      key_col     <= nxt_col;
      contact     <= contact_of(nxt_state, nxt_cnt);
      press_ready <= (nxt_state == IDLE);
      busy        <= (nxt_state != IDLE);
      done        <= (state == GAP) && (nxt_state == IDLE);
    end
  end

  // Physical switch: zero-latency path from row drive to column sense.
  always_comb begin
    col_matrix = 4'b1111;
    if (contact && !lin_matrix[key_row]) col_matrix[key_col] = 1'b0;
  end

endmodule

// File: tb/tb_matrix_key_emulator.sv
// Directed bench for matrix_key_emulator: default instance plus a HOLD=0/GAP=0 boundary instance.
module tb_matrix_key_emulator;

`ifdef KEYEMU_BOUNCE_EN
  localparam int BEFF = 5;
`else
  localparam int BEFF = 0;
`endif
  localparam int D1 = 2 * BEFF + 50 + 20;
  localparam int D2 = 2 * BEFF + 1 + 1;

  logic       clk;
  logic       rst;
  logic       press_req, press_req2;
  logic [3:0] press_code, press_code2;
  logic       press_ready, press_ready2;
  logic [3:0] lin_matrix, lin_matrix2;
  logic [3:0] col_matrix, col_matrix2;
  logic       busy, busy2;
  logic       done, done2;

  int total = 0;
  int bad   = 0;

  logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  matrix_key_emulator dut (
    .clk(clk), .rst(rst), .press_req(press_req), .press_code(press_code),
    .press_ready(press_ready), .lin_matrix(lin_matrix), .col_matrix(col_matrix),
    .busy(busy), .done(done)
  );

  matrix_key_emulator #(.HOLD_CYCLES(0), .BOUNCE_CYCLES(5), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .press_req(press_req2), .press_code(press_code2),
    .press_ready(press_ready2), .lin_matrix(lin_matrix2), .col_matrix(col_matrix2),
    .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Contact level i cycles after the accept edge, with b-cycle bounce windows and h-cycle hold.
  function automatic bit exp_contact(input int i, input int b, input int h);
    if (i < b)              return (i % 2) == 1;
    else if (i < b + h)     return 1'b1;
    else if (i < 2 * b + h) return ((i - b - h) % 2) == 0;
    else                    return 1'b0;
  endfunction

  task automatic run1(input string tag, input logic [3:0] code, input int row, input int col,
                      input logic [3:0] lin_val, input bit rotate);
    logic [3:0] expc;
    bit c;
    press_req  = 1'b1;
    press_code = code;
    step();
    press_req  = 1'b0;
    for (int i = 0; i <= D1; i++) begin
      lin_matrix = rotate ? rot[i % 4] : lin_val;
      #1;
      c    = exp_contact(i, BEFF, 50);
      expc = (c && !lin_matrix[row]) ? ~(4'b0001 << col) : 4'b1111;
      chk4({tag, ".col"}, col_matrix, expc);
      chk1({tag, ".busy"}, busy, i < D1);
      chk1({tag, ".done"}, done, i == D1);
      chk1({tag, ".ready"}, press_ready, i == D1);
      step();
    end
    chk1({tag, ".done_gone"}, done, 1'b0);
  endtask

  initial begin
    bit seen_done, seen_low;
    bit c;
    int n;
    rst         = 1'b1;
    press_req   = 1'b0;
    press_code  = 4'h0;
    lin_matrix  = 4'b0000;
    press_req2  = 1'b0;
    press_code2 = 4'h0;
    lin_matrix2 = 4'b1111;

    for (int i = 0; i < 3; i++) begin
      step();
      chk4("reset.col", col_matrix, 4'b1111);
      chk1("reset.ready", press_ready, 1'b1);
      chk1("reset.busy", busy, 1'b0);
      chk1("reset.done", done, 1'b0);
    end
    rst = 1'b0;
    step();

    // Key 5 is row 1, col 1; scanner rotates row drive every cycle.
    run1("single", 4'h5, 1, 1, 4'b1111, 1'b1);

    // Key F is row 3, col 2; bounce shape visible on col 2.
    run1("bounce", 4'hF, 3, 2, 4'b0111, 1'b0);

    // Busy rejection: key 7 (row 2, col 0) while only row 0 is driven.
    lin_matrix = 4'b1110;
    press_req  = 1'b1;
    press_code = 4'h7;
    step();
    for (int i = 0; i <= D1; i++) begin
      press_req  = (i == 10) || (i == D1);
      press_code = 4'h1;
      #1;
      chk4("reject.col", col_matrix, 4'b1111);
      chk1("reject.done", done, i == D1);
      step();
    end
    press_req = 1'b0;
    #1;
    chk1("reaccept.busy", busy, 1'b1);
    for (int i = 0; i < 10; i++) step();
    #1;
    chk4("reaccept.col", col_matrix, 4'b1110);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk1("reaccept.finish", busy, 1'b0);
    step();

    // Reset mid-press: key D is row 3, col 3.
    lin_matrix = 4'b0111;
    press_req  = 1'b1;
    press_code = 4'hD;
    step();
    press_req = 1'b0;
    for (int i = 0; i < 20; i++) step();
    #1;
    chk4("midrst.pre_col", col_matrix, 4'b0111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk4("midrst.col", col_matrix, 4'b1111);
    chk1("midrst.ready", press_ready, 1'b1);
    chk1("midrst.busy", busy, 1'b0);
    chk1("midrst.done", done, 1'b0);
    seen_done = 1'b0;
    seen_low  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (done) seen_done = 1'b1;
      if (col_matrix != 4'b1111) seen_low = 1'b1;
    end
    chk1("midrst.no_done", seen_done, 1'b0);
    chk1("midrst.no_contact", seen_low, 1'b0);

    // Multi-row drive: key E is row 3, col 0.
    run1("multirow", 4'hE, 3, 0, 4'b0000, 1'b0);

    // Boundary instance: key A is row 0, col 3; HOLD and GAP each one cycle.
    lin_matrix2 = 4'b1110;
    press_req2  = 1'b1;
    press_code2 = 4'hA;
    step();
    press_req2 = 1'b0;
    for (int i = 0; i <= D2; i++) begin
      #1;
      c = exp_contact(i, BEFF, 1);
      chk4("short.col", col_matrix2, c ? 4'b0111 : 4'b1111);
      chk1("short.busy", busy2, i < D2);
      chk1("short.done", done2, i == D2);
      step();
    end
    chk1("short.ready", press_ready2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
